// File: rtl/change_pkg.sv
// ============================================================================
// Module      : change_pkg
// Description : Shared types, coin codes and credit helpers for the dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package change_pkg;

    localparam int               CREDIT_W   = 3;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 3'd4;

    localparam logic COIN_50  = 1'b0;
    localparam logic COIN_100 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VEND = 3'd1,
        ST_PAY  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Codes above CREDIT_MAX come from an accept FSM that over-counted; clamp them.
    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CREDIT_W-1:0] code);
        return (code > CREDIT_MAX) ? CREDIT_MAX : code;
    endfunction

    function automatic logic price_valid(input logic [CREDIT_W-1:0] code);
        return (code != '0) && (code <= CREDIT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ack_timer.sv
// ============================================================================
// Module      : ack_timer
// Description : Counts unacknowledged hopper-request cycles and flags timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ack_timer #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] c_last = TMR_W'(ACK_TIMEOUT - 1);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires during the ACK_TIMEOUT-th consecutive unacknowledged cycle.
    assign expired = enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Vend/refund sequencer paying change through a hopper handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
    import change_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vend,
    input  logic                refund,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [CREDIT_W-1:0] price,
    input  logic                coin_ack,
    output logic                product,
    output logic                coin_req,
    output logic                coin_type,
    output logic                done,
    output logic                reject,
    output logic                busy,
    output logic                err,
    output logic [CREDIT_W-1:0] change_left
);

    state_t              r_state;
    state_t              w_next_state;
    logic [CREDIT_W-1:0] r_remaining;
    logic [CREDIT_W-1:0] w_next_remaining;
    logic                r_reject;
    logic                w_next_reject;

    logic [CREDIT_W-1:0] w_credit_sat;
    logic                w_vend_ok;
    logic                w_coin_sel;
    logic [CREDIT_W-1:0] w_coin_value;
    logic                w_tmr_clear;
    logic                w_tmr_enable;
    logic                w_tmr_expired;

    assign w_credit_sat = sat_credit(credit);
    assign w_vend_ok    = price_valid(price) && (w_credit_sat >= price);

    // Largest coin first; the same selection drives the subtraction.
    assign w_coin_sel   = (r_remaining >= 3'd2) ? COIN_100 : COIN_50;
    assign w_coin_value = (w_coin_sel == COIN_100) ? 3'd2 : 3'd1;

    // Held clear outside PAY so every PAY entry starts from zero.
    assign w_tmr_clear  = (r_state != ST_PAY);
    assign w_tmr_enable = (r_state == ST_PAY) && !coin_ack;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_enable),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_reject    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_reject    <= w_next_reject;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_reject    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (refund) begin
                    w_next_remaining = w_credit_sat;
                    w_next_state     = (w_credit_sat != '0) ? ST_PAY : ST_DONE;
                end else if (vend) begin
                    if (w_vend_ok) begin
                        w_next_remaining = w_credit_sat - price;
                        w_next_state     = ST_VEND;
                    end else begin
                        w_next_reject    = 1'b1;
                    end
                end
            end

            ST_VEND: begin
                w_next_state = (r_remaining != '0) ? ST_PAY : ST_DONE;
            end

            ST_PAY: begin
                if (coin_ack) begin
                    w_next_remaining = r_remaining - w_coin_value;
                    w_next_state     = ST_GAP;
                end else if (w_tmr_expired) begin
                    w_next_state     = ST_ERR;
                end
            end

            // One cycle with the request low so the hopper sees a fresh edge.
            ST_GAP: begin
                w_next_state = (r_remaining != '0) ? ST_PAY : ST_DONE;
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            ST_ERR: begin
                w_next_state = ST_ERR;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign product     = (r_state == ST_VEND);
    assign coin_req    = (r_state == ST_PAY);
    assign coin_type   = (r_state == ST_PAY) ? w_coin_sel : COIN_50;
    assign done        = (r_state == ST_DONE);
    assign reject      = r_reject;
    assign busy        = (r_state != ST_IDLE);
    assign err         = (r_state == ST_ERR);
    assign change_left = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module      : tb_change_dispenser
// Description : Randomised self-checking bench for change_dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vend = 1'b0;
    logic       refund = 1'b0;
    logic       coin_ack = 1'b0;
    logic [2:0] credit = 3'd0;
    logic [2:0] price = 3'd0;
    logic       product, coin_req, coin_type, done, reject, busy, err;
    logic [2:0] change_left;
    logic [9:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {product, coin_req, coin_type, done, reject, busy, err, change_left};

    always #5 clk = ~clk;

    change_dispenser #(
        .ACK_TIMEOUT (15),
        .TMR_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vend        (vend),
        .refund      (refund),
        .credit      (credit),
        .price       (price),
        .coin_ack    (coin_ack),
        .product     (product),
        .coin_req    (coin_req),
        .coin_type   (coin_type),
        .done        (done),
        .reject      (reject),
        .busy        (busy),
        .err         (err),
        .change_left (change_left)
    );

    // One vend/refund transaction against a hopper that acks ack_delay cycles
    // after each request and holds the ack for ack_len cycles.
    task automatic run_txn(input bit do_vend, input bit do_refund, input logic [2:0] cr,
                           input logic [2:0] pr, input int ack_delay, input int ack_len,
                           input bit noise);
        int sc, change, n, t, exp_rise, exp_done_t, rises, acks, rem_exp, wait_cnt, ack_hold;
        bit exp_rej, vend_ok, finished, acked, prev_req;
        int exp_types[$];
        sc       = (cr > 3'd4) ? 4 : int'(cr);
        vend_ok  = !do_refund && do_vend && (pr >= 3'd1) && (pr <= 3'd4) && (sc >= int'(pr));
        exp_rej  = !do_refund && do_vend && !vend_ok;
        change   = do_refund ? sc : (vend_ok ? sc - int'(pr) : 0);
        for (int i = 0; i < change / 2; i++) exp_types.push_back(1);
        if (change % 2 == 1) exp_types.push_back(0);
        n          = exp_types.size();
        exp_rise   = (n > 0) ? (do_refund ? 1 : 2) : -1;
        exp_done_t = (n == 0 && !exp_rej) ? (do_refund ? 1 : 2) : -1;
        rem_exp    = change;
        rises = 0; acks = 0; wait_cnt = 0; ack_hold = 0;
        acked = 1'b0; prev_req = 1'b0; finished = 1'b0; t = 0;

        vend = do_vend; refund = do_refund; credit = cr; price = pr;
        while (!finished && t < 120) begin
            @(posedge clk); #1; t++;
            vend = 1'b0; refund = 1'b0;
            if (coin_ack === 1'b1) begin
                ack_hold--;
                if (ack_hold <= 0) coin_ack = 1'b0;
            end

            if (t == 1) begin
                checks++;
                if (busy !== (exp_rej ? 1'b0 : 1'b1)) begin
                    errors++; $display("FAIL busy_first_cycle: got %b expected %b", busy, !exp_rej);
                end
            end
            checks++;
            if (product !== ((t == 1 && vend_ok) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL product t=%0d: got %b expected %b", t, product, (t == 1 && vend_ok));
            end
            checks++;
            if (reject !== ((t == 1 && exp_rej) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL reject t=%0d: got %b expected %b", t, reject, (t == 1 && exp_rej));
            end
            checks++;
            if (done !== ((t == exp_done_t) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL done t=%0d: got %b expected %b", t, done, (t == exp_done_t));
            end
            checks++;
            if (err !== 1'b0) begin
                errors++; $display("FAIL err_clear t=%0d: got %b expected 0", t, err);
            end
            if (t == exp_rise) begin
                checks++;
                if (coin_req !== 1'b1) begin
                    errors++; $display("FAIL coin_req_rise t=%0d: got %b expected 1", t, coin_req);
                end
            end
            if (coin_req === 1'b1 && !prev_req) begin
                checks++;
                if (t != exp_rise) begin
                    errors++; $display("FAIL coin_req_time: rose at t=%0d expected t=%0d", t, exp_rise);
                end
                checks++;
                if (rises >= n) begin
                    errors++; $display("FAIL coin_extra: coin %0d requested, expected %0d coins", rises + 1, n);
                end else if (coin_type !== logic'(exp_types[rises])) begin
                    errors++; $display("FAIL coin_type #%0d: got %b expected %0d", rises, coin_type, exp_types[rises]);
                end
                checks++;
                if (change_left !== 3'(rem_exp)) begin
                    errors++; $display("FAIL change_left #%0d: got %0d expected %0d", rises, change_left, rem_exp);
                end
                rises++;
            end
            prev_req = (coin_req === 1'b1);

            if (coin_req !== 1'b1) begin
                acked = 1'b0; wait_cnt = 0;
            end else if (!acked) begin
                if (wait_cnt >= ack_delay) begin
                    coin_ack = 1'b1; ack_hold = ack_len; acked = 1'b1;
                    if (acks < n) rem_exp -= (exp_types[acks] == 1) ? 2 : 1;
                    acks++;
                    if (acks >= n) begin
                        exp_done_t = t + 2; exp_rise = -1;
                    end else begin
                        exp_rise = t + 2;
                    end
                end else begin
                    wait_cnt++;
                end
            end

            if (noise && t == 2 && busy === 1'b1) begin
                vend = 1'b1; refund = 1'b1;
            end

            if (exp_rej && t == 2) begin
                finished = 1'b1;
            end else if (!exp_rej && exp_done_t > 0 && t == exp_done_t + 1) begin
                checks++;
                if ({busy, change_left} !== 4'b0000) begin
                    errors++; $display("FAIL idle_after_done: busy=%b change_left=%0d expected 0/0", busy, change_left);
                end
                checks++;
                if (rises != n) begin
                    errors++; $display("FAIL coin_count: got %0d expected %0d", rises, n);
                end
                finished = 1'b1;
            end
        end
        checks++;
        if (!finished) begin
            errors++; $display("FAIL txn_timeout: got no completion in %0d cycles, expected completion", t);
        end
        vend = 1'b0; refund = 1'b0; coin_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL reset_held: got %b expected 0", outs);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 0", outs);
        end
    endtask

    task automatic test_vend_change();
        run_txn(1'b1, 1'b0, 3'd4, 3'd1, 1, 1, 1'b0);
    endtask

    task automatic test_exact_price();
        run_txn(1'b1, 1'b0, 3'd2, 3'd2, 1, 1, 1'b0);
    endtask

    task automatic test_reject();
        run_txn(1'b1, 1'b0, 3'd1, 3'd3, 0, 1, 1'b0);
        run_txn(1'b1, 1'b0, 3'd4, 3'd0, 0, 1, 1'b0);
        run_txn(1'b1, 1'b0, 3'd7, 3'd5, 0, 1, 1'b0);
    endtask

    task automatic test_refund_priority();
        run_txn(1'b1, 1'b1, 3'd3, 3'd1, 0, 2, 1'b0);
        run_txn(1'b0, 1'b1, 3'd0, 3'd1, 0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        credit = 3'd2; price = 3'd1; refund = 1'b1;
        @(posedge clk); #1;
        refund = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if ({coin_req, err} !== 2'b10) begin
                errors++; $display("FAIL timeout_wait c=%0d: req/err got %b%b expected 10", i, coin_req, err);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({err, coin_req, busy} !== 3'b101) begin
            errors++; $display("FAIL timeout_err: err/req/busy got %b%b%b expected 101", err, coin_req, busy);
        end
        vend = 1'b1; refund = 1'b1; credit = 3'd4; coin_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({err, coin_req, product, done} !== 4'b1000) begin
                errors++; $display("FAIL err_sticky: err/req/product/done got %b%b%b%b expected 1000",
                                   err, coin_req, product, done);
            end
        end
        vend = 1'b0; refund = 1'b0; coin_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL err_reset: got %b expected 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_pay();
        credit = 3'd4; refund = 1'b1;
        @(posedge clk); #1;
        refund = 1'b0; coin_ack = 1'b1;
        @(posedge clk); #1;
        coin_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({coin_req, change_left} !== 4'b1010) begin
            errors++; $display("FAIL second_coin_pending: req=%b change_left=%0d expected 1/2", coin_req, change_left);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL async_reset_pay: got %b expected 0", outs);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, busy, coin_req} !== 3'b000) begin
                errors++; $display("FAIL no_done_after_reset: done/busy/req got %b%b%b expected 000", done, busy, coin_req);
            end
        end
        run_txn(1'b0, 1'b1, 3'd4, 3'd1, 0, 1, 1'b0);
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            run_txn(op != 1, op != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vend_change();
        test_exact_price();
        test_reject();
        test_refund_priority();
        test_timeout();
        test_reset_mid_pay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Payout side of the coin vending machine. The coin-accept FSM accumulates credit in 50-unit steps and holds it. This block takes a vend or refund request against that credit. It releases the product, then returns the change as 100- and 50-unit coins through a req/ack handshake with the coin hopper. A one-cycle `done` pulse tells the accept FSM to clear its credit.

## Interface
Parameters:
- ACK_TIMEOUT, 15: maximum cycles `coin_req` may stay high without `coin_ack` before the block faults.
- TMR_W, 4: timeout counter width; must satisfy 2**TMR_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous and active-low; no synchronous reset.
- vend  in  1  single-cycle request pulse (from `oneshot`).
- refund  in  1  single-cycle request pulse (from `oneshot`).
- credit  in  3  held credit code, units of 50 (0..4); codes 5..7 saturate to 4.
- price  in  3  product price code, units of 50 (1..4); 0 or >4 makes every vend a reject.
- coin_ack  in  1  hopper acknowledge; one or more cycles.
- product  out  1  one-cycle product release pulse.
- coin_req  out  1  hopper request, held until acknowledged.
- coin_type  out  1  1 = 100-unit coin, 0 = 50-unit coin; valid while `coin_req`=1.
- done  out  1  one-cycle completion pulse.
- reject  out  1  one-cycle pulse: vend refused, credit below price.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky hopper-timeout fault.
- change_left  out  3  remaining change code, units of 50.

## Operation
- States are IDLE, VEND, PAY, GAP, DONE and ERR. All outputs decode from registered state and registers.
- IDLE:
  - `refund`=1: latch `remaining`=sat(credit), go to PAY if `remaining`>0, else DONE. Refund beats a simultaneous `vend`.
  - `vend`=1 with a valid price and sat(credit) ≥ price: latch `remaining`=sat(credit)−price, go to VEND.
  - `vend`=1 with sat(credit) < price or an invalid price: `reject` pulses for 1 cycle; stay in IDLE.
- VEND: `product`=1 for exactly one cycle. Next state is PAY if `remaining`>0, else DONE.
- PAY:
  - `coin_req`=1. `coin_type`=1 if `remaining` ≥ 2, else 0 (largest coin first).
  - On `coin_ack`=1: `remaining` −= 2 or 1, go to GAP.
  - Otherwise the timer increments. When it reaches ACK_TIMEOUT without an ack, go to ERR.
- GAP: `coin_req`=0 for one cycle, which forces an ack low-phase. Next state is PAY if `remaining`>0, else DONE. A `coin_ack` still high in GAP is ignored.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1, `coin_req`=0, `busy`=1. Inputs are ignored; only `rst` leaves ERR.
- `vend`/`refund` outside IDLE are dropped, not queued.
- The timer clears on entering PAY.
- `remaining` never underflows; subtraction is 3-bit unsigned with the operand chosen by `coin_type`.

## Timing
- Reset values: state IDLE, `remaining`=0, timer=0. Outputs `product`, `coin_req`, `coin_type`, `done`, `reject`, `busy`, `err` and `change_left` are all 0.
- `vend` sampled at edge k → `product` high in cycle k+1. The first `coin_req` rises at edge k+2 when change is due, otherwise `done` at k+2.
- `refund` sampled at edge k → `coin_req` rises at edge k+1.
- `coin_ack` sampled at edge m → `coin_req` low in cycle m+1. The next coin's `coin_req` rises at edge m+2.
- Timeout: `coin_req` high for ACK_TIMEOUT cycles with no ack → ERR at the following edge.
- Reset asserted mid-payout: immediate return to IDLE with `coin_req` dropped. The unpaid change is lost, and `done` does not pulse.

## Structure
- Package `change_pkg` holds:
  - the state enum,
  - localparams COIN_50=1'b0 and COIN_100=1'b1,
  - CREDIT_W=3 and CREDIT_MAX=4,
  - a `sat_credit` function.
- Sub-module `ack_timer` (clear, enable, expired) implements the PAY timeout counter, parameterised by ACK_TIMEOUT and TMR_W.

## Test plan
- credit=4, price=1, `vend` pulse, hopper acks 1 cycle after each req → `product` once; coins 100 then 50; `done`; `change_left` 3→1→0.
- credit=2, price=2, `vend` → `product` at k+1, `done` at k+2, no `coin_req`.
- credit=1, price=3, `vend` → `reject` for 1 cycle, `busy` stays 0, no `product`.
- credit=3, `refund` and `vend` in the same cycle → refund path: coins 100 then 50, no `product`.
- Refund with credit=2 and `coin_ack` held low → after 15 cycles `err`=1 and `coin_req`=0; err stays set; `rst` low clears it.
- Reset pulsed during PAY with credit=4 → all outputs 0 at once, no `done`; a fresh refund after reset pays 100, 100.
